// File: rtl/mips_cache_pkg.sv
// -----------------------------------------------------------------------------
// mips_cache_pkg
// Types and helpers shared by the instruction- and data-cache fill controllers.
//   fill_state_t    : IDLE / REQ / RESP states of a single-read fill FSM
//   WORD_BYTEENABLE : byte enables for a full 32-bit word access
//   word_align()    : clears the byte offset of a byte address
// -----------------------------------------------------------------------------
package mips_cache_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    RESP = 2'b10
  } fill_state_t;

  localparam logic [3:0] WORD_BYTEENABLE = 4'b1111;

  // Masking keeps every address bit visibly consumed; bits [1:0] become zero.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/mips_cache_ctrl_instr.sv
// -----------------------------------------------------------------------------
// mips_cache_ctrl_instr
// Miss-fill controller for the 4-way instruction cache. When the cache raises
// stall it issues one word-aligned 32-bit Avalon-MM read, then hands the word
// back to the cache on data_out with a one-cycle data_valid strobe. A read
// that sees waitrequest for TIMEOUT_CYCLES cycles is abandoned and the sticky
// bus_error flag is set.
//
// Ports
//   clk, rst          : clock (rising edge), asynchronous active-high reset
//   addr, stall       : CPU fetch byte address and cache miss indication
//   data_out          : fill word towards the cache's data_in
//   data_valid        : one-cycle strobe qualifying data_out
//   mem_address       : Avalon word-aligned byte address
//   mem_read          : Avalon read request
//   mem_byteenable    : always all four bytes
//   mem_waitrequest   : Avalon wait request
//   mem_readdata      : Avalon read data
//   bus_error         : sticky read-timeout flag, cleared only by rst
// -----------------------------------------------------------------------------
module mips_cache_ctrl_instr
  import mips_cache_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TIMEOUT_BITS   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic        stall,
  output logic [31:0] data_out,
  output logic        data_valid,
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic [3:0]  mem_byteenable,
  input  logic        mem_waitrequest,
  input  logic [31:0] mem_readdata,
  output logic        bus_error
);

  // Counter value seen during the last permitted waitrequest cycle.
  localparam logic [TIMEOUT_BITS-1:0] CNT_LAST = TIMEOUT_BITS'(TIMEOUT_CYCLES - 1);

  fill_state_t             state_q, state_d;
  logic [31:0]             req_addr_q, req_addr_d;
  logic [31:0]             mem_address_q, mem_address_d;
  logic                    mem_read_q, mem_read_d;
  logic [31:0]             data_out_q, data_out_d;
  logic                    data_valid_q, data_valid_d;
  logic                    bus_error_q, bus_error_d;
  logic [TIMEOUT_BITS-1:0] cnt_q, cnt_d;

  // Next-state and registered-output logic of the fill FSM.
  always_comb begin
    state_d       = state_q;
    req_addr_d    = req_addr_q;
    mem_address_d = mem_address_q;
    mem_read_d    = mem_read_q;
    data_out_d    = data_out_q;
    data_valid_d  = 1'b0;
    bus_error_d   = bus_error_q;
    cnt_d         = cnt_q;

    case (state_q)
      IDLE: begin
        if (stall) begin
          req_addr_d    = word_align(addr);
          mem_address_d = word_align(addr);
          mem_read_d    = 1'b1;
          cnt_d         = '0;
          state_d       = REQ;
        end else begin
          state_d       = IDLE;
        end
      end

      REQ: begin
        if (!mem_waitrequest) begin
          data_out_d   = mem_readdata;
          mem_read_d   = 1'b0;
          // data_valid is a register, so the "is the word still wanted" check
          // is taken on the edge entering RESP; the strobe is then high for
          // the whole RESP cycle, the edge on which the cache writes the line.
          // A PC change during the fill leaves the strobe low and the word
          // is simply dropped.
          data_valid_d = stall && (word_align(addr) == req_addr_q);
          state_d      = RESP;
        end else if (cnt_q == CNT_LAST) begin
          mem_read_d   = 1'b0;
          bus_error_d  = 1'b1;
          state_d      = IDLE;
        end else begin
          // Only reached below CNT_LAST, so the counter cannot wrap.
          cnt_d        = cnt_q + TIMEOUT_BITS'(1);
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        mem_read_d = 1'b0;
        state_d    = IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any in-flight read at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      req_addr_q    <= 32'h0000_0000;
      mem_address_q <= 32'h0000_0000;
      mem_read_q    <= 1'b0;
      data_out_q    <= 32'h0000_0000;
      data_valid_q  <= 1'b0;
      bus_error_q   <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      req_addr_q    <= req_addr_d;
      mem_address_q <= mem_address_d;
      mem_read_q    <= mem_read_d;
      data_out_q    <= data_out_d;
      data_valid_q  <= data_valid_d;
      bus_error_q   <= bus_error_d;
      cnt_q         <= cnt_d;
    end
  end

  assign data_out       = data_out_q;
  assign data_valid     = data_valid_q;
  assign mem_address    = mem_address_q;
  assign mem_read       = mem_read_q;
  assign bus_error      = bus_error_q;
  assign mem_byteenable = WORD_BYTEENABLE;

endmodule

// File: tb/tb_mips_cache_ctrl_instr.sv
// -----------------------------------------------------------------------------
// tb_mips_cache_ctrl_instr
// Self-checking bench for the instruction-cache fill controller, built with a
// short timeout (4 cycles). Directed cases come from a vector table, a few
// cycle-exact sequences cover retry, reset and back-to-back fills, and random
// misses are predicted by a transaction-level model (reads issued, their
// lengths, the word returned and the sticky error flag).
// -----------------------------------------------------------------------------
module tb_mips_cache_ctrl_instr;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic        stall;
  logic [31:0] data_out;
  logic        data_valid;
  logic [31:0] mem_address;
  logic        mem_read;
  logic [3:0]  mem_byteenable;
  logic        mem_waitrequest;
  logic [31:0] mem_readdata;
  logic        bus_error;

  int total = 0;
  int bad   = 0;

  mips_cache_ctrl_instr #(
    .TIMEOUT_CYCLES(T),
    .TIMEOUT_BITS  (3)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .addr           (addr),
    .stall          (stall),
    .data_out       (data_out),
    .data_valid     (data_valid),
    .mem_address    (mem_address),
    .mem_read       (mem_read),
    .mem_byteenable (mem_byteenable),
    .mem_waitrequest(mem_waitrequest),
    .mem_readdata   (mem_readdata),
    .bus_error      (bus_error)
  );

  always #5 clk = ~clk;

  // Memory contents: chosen so that 0xBFC00004 holds 0x24020005.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h9BC2_0001;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    int          chg;     // read-cycle index at which addr switches to b
    int          w;       // waitrequest cycles per read
    int          exp_nr;
    logic [31:0] exp_a0;
    int          exp_l0;
    logic [31:0] exp_a1;
    int          exp_l1;
    int          exp_nv;
    logic [31:0] exp_d;
    logic        exp_berr;
  } vec_t;

  // Transaction-level prediction of one miss episode.
  function automatic vec_t predict(input logic [31:0] a, input logic [31:0] b,
                                   input int chg, input int w, input logic berr_in);
    vec_t v;
    v.a = a; v.b = b; v.chg = chg; v.w = w;
    v.exp_a0 = {a[31:2], 2'b00};
    v.exp_a1 = {b[31:2], 2'b00};
    v.exp_l1 = 0;
    v.exp_d  = 32'h0;
    if (w >= T) begin
      v.exp_nr = 1; v.exp_l0 = T; v.exp_nv = 0; v.exp_berr = 1'b1;
    end else begin
      v.exp_l0 = w + 1; v.exp_nv = 1; v.exp_berr = berr_in;
      if (chg <= w && v.exp_a1 != v.exp_a0) begin
        v.exp_nr = 2; v.exp_l1 = w + 1; v.exp_d = mem_word(v.exp_a1);
      end else begin
        v.exp_nr = 1; v.exp_d = mem_word(v.exp_a0);
      end
    end
    return v;
  endfunction

  // Run one miss: the bench plays cache (stall/addr) and memory, logs the
  // reads it sees, then compares against the vector's expectations.
  task automatic run_vec(input vec_t v, input string tag);
    int nr = 0, k = 0, nv = 0, tail = 0;
    int len0 = 0, len1 = 0;
    logic [31:0] ra0 = 32'h0, ra1 = 32'h0, vd = 32'h0;
    bit prev_rd = 1'b0, last_wr = 1'b1, done = 1'b0, lat_ok = 1'b1, stable = 1'b1;
    @(negedge clk);
    addr  = v.a;
    stall = 1'b1;
    for (int cyc = 0; cyc < 80 && tail < 3; cyc++) begin
      @(negedge clk);
      if (done) tail++;
      if (data_valid) begin
        nv++;
        vd = data_out;
        if (!(prev_rd && !mem_read)) lat_ok = 1'b0;
        stall = 1'b0;
        done  = 1'b1;
      end else if (prev_rd && !mem_read && last_wr) begin
        // read abandoned while wait was still asserted: the cache gives up
        stall = 1'b0;
        done  = 1'b1;
      end
      if (mem_read) begin
        if (!prev_rd) begin
          nr++;
          k = 0;
          if (nr == 1) ra0 = mem_address;
          if (nr == 2) ra1 = mem_address;
        end else if ((nr == 1 && mem_address !== ra0) || (nr == 2 && mem_address !== ra1)) begin
          stable = 1'b0;
        end
        if (nr == 1) len0++;
        if (nr == 2) len1++;
        mem_waitrequest = (k < v.w);
        mem_readdata    = mem_waitrequest ? 32'hDEAD_BEEF : mem_word(mem_address);
        if (nr == 1 && k == v.chg) addr = v.b;
        k++;
      end else begin
        mem_waitrequest = 1'b1;
        mem_readdata    = 32'h0;
      end
      last_wr = mem_waitrequest;
      prev_rd = mem_read;
    end
    check({tag, ".done"},   32'(done),   32'd1);
    check({tag, ".nreads"}, 32'(nr),     32'(v.exp_nr));
    check({tag, ".addr0"},  ra0,         v.exp_a0);
    check({tag, ".len0"},   32'(len0),   32'(v.exp_l0));
    if (v.exp_nr == 2) begin
      check({tag, ".addr1"}, ra1,        v.exp_a1);
      check({tag, ".len1"},  32'(len1),  32'(v.exp_l1));
    end
    check({tag, ".nvalid"}, 32'(nv),     32'(v.exp_nv));
    if (v.exp_nv == 1) begin
      check({tag, ".data"},    vd,          v.exp_d);
      check({tag, ".latency"}, 32'(lat_ok), 32'd1);
    end
    check({tag, ".addr_stable"}, 32'(stable), 32'd1);
    check({tag, ".bus_error"},   32'(bus_error), 32'(v.exp_berr));
  endtask

  vec_t table_v[5];
  logic berr_model;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // a, b, chg, w, nr, a0, l0, a1, l1, nv, data, berr
    table_v[0] = '{32'hBFC0_0004, 32'hBFC0_0004, 99, 0, 1, 32'hBFC0_0004, 1, 32'h0, 0, 1, 32'h2402_0005, 1'b0};
    table_v[1] = '{32'h0000_0013, 32'h0000_0013, 99, 3, 1, 32'h0000_0010, 4, 32'h0, 0, 1, 32'h9BC2_0011, 1'b0};
    table_v[2] = '{32'h0000_0100, 32'h0000_0200, 1,  2, 2, 32'h0000_0100, 3, 32'h0000_0200, 3, 1, 32'h9BC2_0201, 1'b0};
    table_v[3] = '{32'h0000_0020, 32'h0000_0020, 99, 6, 1, 32'h0000_0020, 4, 32'h0, 0, 0, 32'h0, 1'b1};
    table_v[4] = '{32'h0000_0037, 32'h0000_0037, 99, 1, 1, 32'h0000_0034, 2, 32'h0, 0, 1, 32'h9BC2_0035, 1'b1};

    rst = 1'b1; addr = 32'h0; stall = 1'b0;
    mem_waitrequest = 1'b1; mem_readdata = 32'h0;
    @(negedge clk);
    @(negedge clk);
    check("rst.mem_read",    32'(mem_read),       32'd0);
    check("rst.mem_address", mem_address,         32'h0);
    check("rst.data_out",    data_out,            32'h0);
    check("rst.data_valid",  32'(data_valid),     32'd0);
    check("rst.bus_error",   32'(bus_error),      32'd0);
    check("byteenable",      32'(mem_byteenable), 32'hF);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) run_vec(table_v[i], $sformatf("vec%0d", i));

    // Timeout with stall held: retry begins right after the abandoned read.
    @(negedge clk);
    addr = 32'h0000_0040; stall = 1'b1;
    for (int i = 0; i < T; i++) begin
      @(negedge clk);
      check("to.mem_read_hi", 32'(mem_read), 32'd1);
    end
    @(negedge clk);
    check("to.mem_read_drop", 32'(mem_read),   32'd0);
    check("to.bus_error",     32'(bus_error),  32'd1);
    check("to.no_valid",      32'(data_valid), 32'd0);
    @(negedge clk);
    check("to.retry_read", 32'(mem_read), 32'd1);
    check("to.retry_addr", mem_address,   32'h0000_0040);
    mem_waitrequest = 1'b0; mem_readdata = mem_word(32'h0000_0040);
    @(negedge clk);
    check("to.retry_valid", 32'(data_valid), 32'd1);
    check("to.retry_data",  data_out,        32'h9BC2_0041);
    stall = 1'b0; mem_waitrequest = 1'b1; mem_readdata = 32'h0;
    @(negedge clk);
    check("to.sticky", 32'(bus_error), 32'd1);

    // Reset during REQ drops the read at once and clears bus_error.
    @(negedge clk);
    addr = 32'h0000_0080; stall = 1'b1;
    @(negedge clk);
    check("rq.mem_read", 32'(mem_read), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rq.async_drop", 32'(mem_read),  32'd0);
    check("rq.berr_clear", 32'(bus_error), 32'd0);
    stall = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rq.quiet_read",  32'(mem_read),   32'd0);
      check("rq.quiet_valid", 32'(data_valid), 32'd0);
    end

    // Back-to-back misses at 0x0 then 0x4, zero wait states.
    addr = 32'h0; stall = 1'b1;
    @(negedge clk);
    check("bb.read0", 32'(mem_read), 32'd1);
    check("bb.addr0", mem_address,   32'h0);
    mem_waitrequest = 1'b0; mem_readdata = mem_word(32'h0);
    @(negedge clk);
    check("bb.valid0", 32'(data_valid), 32'd1);
    check("bb.data0",  data_out,        32'h9BC2_0001);
    check("bb.noovl0", 32'(mem_read),   32'd0);
    addr = 32'h4; mem_waitrequest = 1'b1; mem_readdata = 32'h0;
    @(negedge clk);
    check("bb.gap_read",  32'(mem_read),   32'd0);
    check("bb.gap_valid", 32'(data_valid), 32'd0);
    @(negedge clk);
    check("bb.read1", 32'(mem_read), 32'd1);
    check("bb.addr1", mem_address,   32'h4);
    mem_waitrequest = 1'b0; mem_readdata = mem_word(32'h4);
    @(negedge clk);
    check("bb.valid1", 32'(data_valid), 32'd1);
    check("bb.data1",  data_out,        32'h9BC2_0005);
    stall = 1'b0; mem_waitrequest = 1'b1; mem_readdata = 32'h0;
    @(negedge clk);
    check("bb.end_valid", 32'(data_valid), 32'd0);
    @(negedge clk);
    check("bb.no_retrig", 32'(mem_read), 32'd0);

    // Random misses against the transaction model.
    berr_model = 1'b0;
    for (int i = 0; i < 40; i++) begin
      logic [31:0] ra, rb;
      vec_t v;
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? (ra ^ 32'h1) : $urandom;
      v  = predict(ra, rb, $urandom_range(0, 6), $urandom_range(0, 6), berr_model);
      run_vec(v, $sformatf("rnd%0d", i));
      berr_model = v.exp_berr;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
